// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two combinational read ports, one byte-enabled write
// port, optional hardwired-zero entry and a sequential bulk-clear engine. Macro: REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  input  logic                clr_req,
  output logic                busy,
  output logic                clr_done,
  output logic                wr_drop
);

  localparam int unsigned       NB        = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              clr_done_q;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic clearing;
  logic waddr_ok;
  logic wr_ok;
  logic wr_drop_d;

  always_comb begin
    clearing  = (state_q == StClear);
    waddr_ok  = ({1'b0, waddr} < DEPTH_EXT) && !((ZERO_REG != 0) && (waddr == '0));
    wr_ok     = we && waddr_ok && !clearing;
    // An all-zero byte mask never counts as a dropped write.
    wr_drop_d = we && (|wbe) && !(waddr_ok && !clearing);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      wr_drop_q  <= wr_drop_d;
      clr_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          if (cnt_q == LAST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Raised so it is high during the cycle the last entry is being cleared.
            if (cnt_q == LAST - 1'b1) clr_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (clearing && (cnt_q == ADDR_W'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_ok && (waddr == ADDR_W'(i))) begin
          for (int b = 0; b < int'(NB); b++) begin
            if (wbe[b]) mem_q[i][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (a == ADDR_W'(i)) v = mem_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (a == waddr)) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wbe[b]) v[8*b +: 8] = wdata[8*b +: 8];
      end
    end
`endif
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

  assign busy     = (state_q == StClear);
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp (DEPTH=32, ADDR_W=6 so out-of-range is reachable),
// compared every cycle against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DP = 32;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [3:0]    wbe;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          clr_req;
  logic          busy;
  logic          clr_done;
  logic          wr_drop;

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (DP),
    .ZERO_REG(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wbe     (wbe),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_done(clr_done),
    .wr_drop (wr_drop)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: stored words, cycles of clearing still to go, last-edge drop flag.
  logic [31:0] m_mem [DP];
  int          clr_left;
  logic        m_drop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    logic [31:0] v;
    if (int'(a) >= DP || a == 0) return 32'h0;
    v = m_mem[int'(a)];
`ifdef REGFILE_BYPASS_EN
    if (we && clr_left == 0 && waddr == a) v = merge(v, wdata, wbe);
`endif
    return v;
  endfunction

  // Model update on each clock edge; asynchronous reset wipes it.
  initial begin
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    clr_left = 0;
    m_drop   = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
        clr_left = 0;
        m_drop   = 1'b0;
      end else begin
        bit ok_addr;
        ok_addr = (int'(waddr) < DP) && (waddr != 0);
        m_drop  = we && (wbe != 0) && !(ok_addr && clr_left == 0);
        if (we && ok_addr && clr_left == 0) m_mem[int'(waddr)] = merge(m_mem[int'(waddr)], wdata, wbe);
        if (clr_left > 0) begin
          m_mem[DP - clr_left] = '0;
          clr_left--;
        end else if (clr_req) begin
          clr_left = DP;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("rdata1", rdata1, exp_rd(raddr1));
      chk("rdata2", rdata2, exp_rd(raddr2));
      chk("busy", 32'(busy), 32'(clr_left > 0));
      chk("clr_done", 32'(clr_done), 32'(clr_left == 1));
      chk("wr_drop", 32'(wr_drop), 32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = AW'(a); wdata = d; wbe = be;
    step();
    we = 1'b0; wbe = '0;
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [31:0] exp);
    raddr1 = AW'(a);
    raddr2 = AW'(a);
    #1;
    chk(nm, rdata1, exp);
    chk(nm, rdata2, exp);
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) step();
    chk("wait_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    rst_n = 1'b0; we = 1'b0; wbe = '0; waddr = '0; wdata = '0;
    raddr1 = 6'd5; raddr2 = 6'd0; clr_req = 1'b0;
    #3;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rdata", rdata1, 32'h0);
    #20 rst_n = 1'b1;
    step();
    for (int a = 0; a < 64; a++) rd_chk("reset_read", a, 32'h0);

    wr(5, 32'hDEADBEEF, 4'hF);
    rd_chk("wr_full", 5, 32'hDEADBEEF);
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'b0101);
    rd_chk("wr_bytes", 7, 32'h11BB33DD);

    wr(0, 32'hFFFFFFFF, 4'hF);
    raddr1 = 6'd0;
    #1;
    chk("zero_drop", 32'(wr_drop), 32'h1);
    chk("zero_read", rdata1, 32'h0);
    wr(32, 32'h55555555, 4'hF);
    #1;
    chk("oor_drop", 32'(wr_drop), 32'h1);
    wr(40, 32'h12121212, 4'h0);
    #1;
    chk("nobe_nodrop", 32'(wr_drop), 32'h0);
    rd_chk("oor_read", 32, 32'h0);
    rd_chk("oor_keep5", 5, 32'hDEADBEEF);

    we = 1'b1; waddr = 6'd9; wdata = 32'h12345678; wbe = 4'hF; raddr2 = 6'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre", rdata2, 32'h12345678);
`else
    chk("bypass_pre", rdata2, 32'h0);
`endif
    step();
    we = 1'b0; wbe = '0;
    #1;
    chk("bypass_post", rdata2, 32'h12345678);

    for (int c = 0; c < 500; c++) begin
      we      = 1'($urandom_range(0, 1));
      wbe     = 4'($urandom);
      waddr   = AW'($urandom_range(0, 40));
      wdata   = $urandom;
      raddr1  = AW'($urandom_range(0, 63));
      raddr2  = AW'($urandom_range(0, 63));
      clr_req = ($urandom_range(0, 39) == 0);
      step();
    end
    we = 1'b0; wbe = '0; clr_req = 1'b0;
    wait_idle();

    for (int i = 1; i < DP; i++) wr(i, 32'(i), 4'hF);
    rd_chk("fill17", 17, 32'd17);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy) busy_cnt++;
      if (clr_done) done_at = busy_cnt;
      if (c == 6) begin
        chk("clear_wr_drop", 32'(wr_drop), 32'h1);
        we = 1'b0; wbe = '0;
      end
      if (c == 5) begin
        we = 1'b1; waddr = 6'd3; wdata = 32'hFACEFACE; wbe = 4'hF;
      end
      step();
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("clear_done_pos", 32'(done_at), 32'd32);
    for (int a = 0; a < DP; a++) rd_chk("cleared", a, 32'h0);

    wr(22, 32'hCAFE0016, 4'hF);
    wr(30, 32'h0BADF00D, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    raddr1 = 6'd22;
    #1;
    chk("pre_rst_22", rdata1, 32'hCAFE0016);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_rdata", rdata1, 32'h0);
    chk("async_done", 32'(clr_done), 32'h0);
    for (int a = 0; a < DP; a++) rd_chk("async_read", a, 32'h0);
    #1 rst_n = 1'b1;
    step();
    repeat (3) step();
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
